// File: rtl/dmem_map_pkg.sv
// Address map and STATUS register layout shared by the data-memory responder
// and anything that decodes its MMIO window.
package dmem_map_pkg;

    localparam logic [31:0] MMIO_SAMPLE_IN = 32'h0000_1000;
    localparam logic [31:0] MMIO_STATUS    = 32'h0000_1001;
    localparam logic [31:0] MMIO_RESULT    = 32'h0000_1002;
    localparam logic [31:0] MMIO_CYCLES    = 32'h0000_1003;

    // STATUS = {16'b0, ovf, r_empty, r_full, s_empty, s_full, 3'b0, r_count, s_count}
    // zero-extended; both counts share the low byte, so the flags start at bit 11.
    localparam int STATUS_OVF_BIT     = 15;
    localparam int STATUS_R_EMPTY_BIT = 14;
    localparam int STATUS_R_FULL_BIT  = 13;
    localparam int STATUS_S_EMPTY_BIT = 12;
    localparam int STATUS_S_FULL_BIT  = 11;
    localparam int STATUS_R_COUNT_LSB = 4;
    localparam int STATUS_S_COUNT_LSB = 0;

    function automatic logic [31:0] status_pack(
        input logic       ovf,
        input logic       r_empty,
        input logic       r_full,
        input logic       s_empty,
        input logic       s_full,
        input logic [3:0] r_count,
        input logic [3:0] s_count
    );
        logic [31:0] w;
        w = '0;
        w[STATUS_OVF_BIT]     = ovf;
        w[STATUS_R_EMPTY_BIT] = r_empty;
        w[STATUS_R_FULL_BIT]  = r_full;
        w[STATUS_S_EMPTY_BIT] = s_empty;
        w[STATUS_S_FULL_BIT]  = s_full;
        w[STATUS_R_COUNT_LSB +: 4] = r_count;
        w[STATUS_S_COUNT_LSB +: 4] = s_count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with simultaneous push/pop; head reads 0 while empty.
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // A push is judged against the occupancy before the edge, so a full FIFO
    // refuses it even when a pop frees a slot in the same cycle.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with asynchronous read plus an MMIO window
// that streams samples to the FFT engine and collects its results.
module dmem_responder
    import dmem_map_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_data,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data
);

    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int RAM_WORDS = 1 << RAM_ADDR_WIDTH;

    logic [31:0] ram [RAM_WORDS] = '{default: '0};

    logic                      in_ram;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      wr_sample;
    logic                      wr_status;
    logic                      wr_result;
    logic                      wr_cycles;

    logic          s_full, s_empty, r_full, r_empty;
    logic [CW-1:0] s_count, r_count;
    logic [31:0]   r_head;
    logic [31:0]   status_word;
    logic          ovf;
    logic [31:0]   cycles_q;

    assign in_ram    = ((address_dmem >> RAM_ADDR_WIDTH) == 32'd0);
    assign ram_idx   = address_dmem[RAM_ADDR_WIDTH-1:0];
    assign wr_sample = wren && (address_dmem == MMIO_SAMPLE_IN);
    assign wr_status = wren && (address_dmem == MMIO_STATUS);
    assign wr_result = wren && (address_dmem == MMIO_RESULT);
    assign wr_cycles = wren && (address_dmem == MMIO_CYCLES);

    // Both streams use valid/ready: a word moves on a rising edge where valid
    // and ready are both high; valid never waits on ready.
    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_sample_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wr_sample),
        .push_data (data),
        .pop       (s_ready),
        .full      (s_full),
        .empty     (s_empty),
        .count     (s_count),
        .head      (s_data)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_result_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (r_valid),
        .push_data (r_data),
        .pop       (wr_result),
        .full      (r_full),
        .empty     (r_empty),
        .count     (r_count),
        .head      (r_head)
    );

    assign s_valid = !s_empty;
    assign r_ready = !r_full;

    assign status_word = status_pack(ovf, r_empty, r_full, s_empty, s_full,
                                     4'(r_count), 4'(s_count));

    // MMIO decode wins over RAM so a wider RAM can never shadow the window.
    always_comb begin
        q_dmem = '0;
        if (address_dmem == MMIO_STATUS) begin
            q_dmem = status_word;
        end else if (address_dmem == MMIO_RESULT) begin
            q_dmem = r_head;
        end else if (address_dmem == MMIO_CYCLES) begin
            q_dmem = cycles_q;
        end else if (address_dmem != MMIO_SAMPLE_IN && in_ram) begin
            q_dmem = ram[ram_idx];
        end
    end

    // RAM contents survive reset, but a store issued during reset is dropped.
    always_ff @(posedge clock) begin
        if (reset && wren && in_ram) begin
            ram[ram_idx] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ovf      <= 1'b0;
            cycles_q <= '0;
        end else begin
            if (wr_status) begin
                ovf <= 1'b0;
            end else if (wr_sample && s_full) begin
                ovf <= 1'b1;
            end
            cycles_q <= wr_cycles ? 32'd0 : cycles_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic scored
// against a queue-level model of the memory map.
module tb_dmem_responder;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [31:0] s_data;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [31:0] r_data = '0;

    always #5 clock = ~clock;

    dmem_responder #(.RAM_ADDR_WIDTH(12), .FIFO_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_data       (r_data)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard queues
    logic [31:0] rd_exp_q[$];
    logic [1:0]  flag_exp_q[$];
    logic [31:0] s_exp_q[$];

    // Reference model state
    logic [31:0] m_ram [int];
    logic [31:0] m_sq[$];
    logic [31:0] m_rq[$];
    bit          m_ovf = 1'b0;
    logic [31:0] m_cyc = '0;
    bit          m_valid = 1'b0;
    bit          pre_en = 1'b0;
    logic [31:0] pre_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] w;
        w = 32'(m_sq.size()) + 32'(m_rq.size()) * 16;
        if (m_sq.size() == DEPTH) w = w + 32'h0800;
        if (m_sq.size() == 0)     w = w + 32'h1000;
        if (m_rq.size() == DEPTH) w = w + 32'h2000;
        if (m_rq.size() == 0)     w = w + 32'h4000;
        if (m_ovf)                w = w + 32'h8000;
        return w;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == 32'h1000) return 32'h0;
        if (a == 32'h1001) return m_status();
        if (a == 32'h1002) return (m_rq.size() > 0) ? m_rq[0] : 32'h0;
        if (a == 32'h1003) return m_cyc;
        if (a < 32'd4096) return m_ram.exists(int'(a)) ? m_ram[int'(a)] : 32'h0;
        return 32'h0;
    endfunction

    // One processor cycle: drive inputs, record expectations, advance the model.
    task automatic step(input bit rst, input logic [31:0] addr, input logic [31:0] wd,
                        input bit wr, input bit sr, input bit rv, input logic [31:0] rd);
        bit s_pop, s_acc, r_psh, r_pop;
        @(posedge clock);
        #1;
        if (pre_en) begin
            force dut.cycles_q = pre_val;
            #1;
            release dut.cycles_q;
            m_cyc  = pre_val;
            pre_en = 1'b0;
        end
        reset = rst; address_dmem = addr; data = wd; wren = wr;
        s_ready = sr; r_valid = rv; r_data = rd;
        if (m_valid) begin
            rd_exp_q.push_back(m_read(addr));
            flag_exp_q.push_back({m_sq.size() != 0, m_rq.size() != DEPTH});
        end
        if (!rst) begin
            m_sq.delete(); m_rq.delete(); s_exp_q.delete();
            m_ovf = 1'b0; m_cyc = '0; m_valid = 1'b1;
            return;
        end
        s_pop = sr && (m_sq.size() > 0);
        s_acc = wr && (addr == 32'h1000) && (m_sq.size() < DEPTH);
        r_psh = rv && (m_rq.size() < DEPTH);
        r_pop = wr && (addr == 32'h1002) && (m_rq.size() > 0);
        if (wr && addr == 32'h1000 && !s_acc) m_ovf = 1'b1;
        if (wr && addr == 32'h1001) m_ovf = 1'b0;
        if (s_pop) void'(m_sq.pop_front());
        if (s_acc) begin
            m_sq.push_back(wd);
            s_exp_q.push_back(wd);
        end
        if (r_pop) void'(m_rq.pop_front());
        if (r_psh) m_rq.push_back(rd);
        m_cyc = (wr && addr == 32'h1003) ? 32'h0 : m_cyc + 32'h1;
        if (wr && addr < 32'd4096) m_ram[int'(addr)] = wd;
    endtask

    task automatic rd_cyc(input logic [31:0] addr);
        step(1'b1, addr, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic wr_cyc(input logic [31:0] addr, input logic [31:0] wd);
        step(1'b1, addr, wd, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic expect_rd(input string name, input logic [31:0] exp);
        @(negedge clock);
        #1;
        check(name, q_dmem, exp);
    endtask

    // Monitor: compares whatever the DUT presents this cycle against the queues.
    logic [1:0] mon_f;
    always @(negedge clock) begin
        if (flag_exp_q.size() > 0) begin
            mon_f = flag_exp_q.pop_front();
            check("s_valid", {31'b0, s_valid}, {31'b0, mon_f[1]});
            check("r_ready", {31'b0, r_ready}, {31'b0, mon_f[0]});
        end
        if (rd_exp_q.size() > 0) begin
            check("q_dmem", q_dmem, rd_exp_q.pop_front());
        end
        if (reset && s_valid && s_ready) begin
            if (s_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_data: handshake got %08h with no sample expected", s_data);
            end else begin
                check("s_data", s_data, s_exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        rd_cyc(32'h1003);
        expect_rd("cycles_after_reset", 32'h0);
        check("s_data_after_reset", s_data, 32'h0);
        check("s_valid_after_reset", {31'b0, s_valid}, 32'h0);
        check("r_ready_after_reset", {31'b0, r_ready}, 32'h1);
        rd_cyc(32'h1001);
        expect_rd("status_after_reset", 32'h0000_5000);

        // RAM store then load, unmapped read
        wr_cyc(32'd5, 32'hDEAD_BEEF);
        rd_cyc(32'd5);
        expect_rd("ram_load_after_store", 32'hDEAD_BEEF);
        rd_cyc(32'h2000);
        expect_rd("unmapped_read", 32'h0);

        // Sample FIFO fill and overflow
        for (int i = 1; i <= 8; i++) wr_cyc(32'h1000, 32'(i));
        wr_cyc(32'h1000, 32'd9);
        rd_cyc(32'h1001);
        expect_rd("status_overflow", 32'h0000_C808);
        for (int i = 0; i < 9; i++) step(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clock);
        check("s_valid_drained", {31'b0, s_valid}, 32'h0);
        rd_cyc(32'h1001);
        expect_rd("status_drained_ovf", 32'h0000_D000);
        wr_cyc(32'h1001, 32'h0);
        rd_cyc(32'h1001);
        expect_rd("status_ovf_cleared", 32'h0000_5000);

        // Result FIFO peek and pop
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11);
        step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h22);
        rd_cyc(32'h1002);
        expect_rd("result_peek1", 32'h11);
        rd_cyc(32'h1002);
        expect_rd("result_peek2", 32'h11);
        wr_cyc(32'h1002, 32'h0);
        rd_cyc(32'h1002);
        expect_rd("result_after_pop", 32'h22);
        wr_cyc(32'h1002, 32'h0);
        wr_cyc(32'h1002, 32'h0);
        rd_cyc(32'h1001);
        expect_rd("status_result_empty", 32'h0000_5000);

        // Result FIFO full, then pop/push at count 7
        for (int i = 0; i < 8; i++) step(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100 + 32'(i));
        rd_cyc(32'h1001);
        expect_rd("status_result_full", 32'h0000_3080);
        check("r_ready_full", {31'b0, r_ready}, 32'h0);
        step(1'b1, 32'h1002, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200);
        rd_cyc(32'h1001);
        expect_rd("status_count7", 32'h0000_1070);
        step(1'b1, 32'h1002, 32'h0, 1'b1, 1'b0, 1'b1, 32'h201);
        rd_cyc(32'h1001);
        expect_rd("status_push_pop_7", 32'h0000_1070);
        rd_cyc(32'h1002);
        expect_rd("result_head_after_pops", 32'h102);

        // Cycle counter load and wrap
        wr_cyc(32'h1003, 32'h0);
        for (int k = 0; k < 4; k++) begin
            rd_cyc(32'h1003);
            expect_rd("cycles_after_load", 32'(k));
        end
        pre_en = 1'b1;
        pre_val = 32'hFFFF_FFFE;
        rd_cyc(32'h1003);
        expect_rd("cycles_preload", 32'hFFFF_FFFE);
        rd_cyc(32'h1003);
        expect_rd("cycles_max", 32'hFFFF_FFFF);
        rd_cyc(32'h1003);
        expect_rd("cycles_wrap", 32'h0);

        // Mid-stream reset with both FIFOs partly full and ovf set
        for (int i = 0; i < 9; i++) wr_cyc(32'h1000, 32'h500 + 32'(i));
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'd5, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 32'h55);
        rd_cyc(32'h1003);
        expect_rd("cycles_after_midreset", 32'h0);
        check("s_data_after_midreset", s_data, 32'h0);
        rd_cyc(32'h1001);
        expect_rd("status_after_midreset", 32'h0000_5000);
        rd_cyc(32'd5);
        expect_rd("ram_survives_reset", 32'hDEAD_BEEF);

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0, 1:    a = 32'($urandom_range(0, 15));
                2, 3:    a = 32'h1000 + 32'($urandom_range(0, 3));
                4:       a = 32'h2000;
                default: a = $urandom;
            endcase
            step($urandom_range(0, 99) != 0, a, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), $urandom);
        end
        rd_cyc(32'h0);
        repeat (3) @(posedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
